// File: rtl/fifo_256i_16o_pkg.sv
// rtl/fifo_256i_16o_pkg.sv - shared widths and ratio for the 256-in / 16-out FIFO
package fifo_256i_16o_pkg;
  localparam int WR_WIDTH = 256;
  localparam int RD_WIDTH = 16;
  localparam int RATIO    = 16;
  localparam int WR_LVL_W = 11;
  localparam int RD_LVL_W = 15;
  localparam int SUB_W    = $clog2(RATIO);
endpackage

// File: rtl/fifo_256i_16o_if.sv
// rtl/fifo_256i_16o_if.sv - write/read bus of the 256-in / 16-out FIFO
interface fifo_256i_16o_if;
  import fifo_256i_16o_pkg::*;

  logic                wr_en;
  logic [WR_WIDTH-1:0] wr_data;
  logic                wr_full;
  logic [WR_LVL_W-1:0] wr_water_level;
  logic                almost_full;
  logic                rd_en;
  logic [RD_WIDTH-1:0] rd_data;
  logic                rd_empty;
  logic [RD_LVL_W-1:0] rd_water_level;
  logic                almost_empty;

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_full, wr_water_level, almost_full,
    input  rd_data, rd_empty, rd_water_level, almost_empty
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_full, wr_water_level, almost_full,
    output rd_data, rd_empty, rd_water_level, almost_empty
  );
endinterface

// File: rtl/fifo_mem_sp256.sv
// rtl/fifo_mem_sp256.sv - DEPTH x 256 dual-port RAM with registered read and 16-bit slice select
module fifo_mem_sp256
  import fifo_256i_16o_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WR_WIDTH-1:0] wr_data,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  input  logic [SUB_W-1:0]    rd_sel,
  output logic [RD_WIDTH-1:0] rd_data
);
  logic [RATIO-1:0][RD_WIDTH-1:0] mem [DEPTH];
  logic [RATIO-1:0][RD_WIDTH-1:0] word_q;
  logic [SUB_W-1:0]               sel_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      sel_q  <= '0;
    end else if (rd_en) begin
      word_q <= mem[rd_addr];
      sel_q  <= rd_sel;
    end
  end

  assign rd_data = word_q[sel_q];
endmodule

// File: rtl/fifo_256i_16o.sv
// rtl/fifo_256i_16o.sv - width-converting FIFO: 256-bit writes, 16-bit LSB-first reads
module fifo_256i_16o
  import fifo_256i_16o_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int AF_LEVEL = 1008,
  parameter int AE_LEVEL = 16
) (
  input  logic               clk,
  input  logic               rst,
  fifo_256i_16o_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [SUB_W-1:0]    sub_idx;
  logic [RD_LVL_W-1:0] cnt;
  logic [RD_LVL_W-1:0] cnt_nxt;
  logic [WR_LVL_W-1:0] wr_level;
  logic                wr_acc;
  logic                rd_acc;

  // A partly-read word still holds its slot, so the slot count rounds up.
  assign wr_level = cnt[RD_LVL_W-1:SUB_W] + WR_LVL_W'(|cnt[SUB_W-1:0]);

  assign bus.wr_water_level = wr_level;
  assign bus.rd_water_level = cnt;
  assign bus.wr_full        = (wr_level == WR_LVL_W'(DEPTH));
  assign bus.rd_empty       = (cnt == '0);
  assign bus.almost_full    = (wr_level >= WR_LVL_W'(AF_LEVEL));
  assign bus.almost_empty   = (cnt <= RD_LVL_W'(AE_LEVEL));

  assign wr_acc = bus.wr_en & ~bus.wr_full & ~rst;
  assign rd_acc = bus.rd_en & ~bus.rd_empty & ~rst;

  always_comb begin
    cnt_nxt = cnt;
    if (wr_acc) cnt_nxt = cnt_nxt + RD_LVL_W'(RATIO);
    if (rd_acc) cnt_nxt = cnt_nxt - RD_LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      sub_idx <= '0;
      cnt     <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        sub_idx <= sub_idx + SUB_W'(1);
        if (sub_idx == SUB_W'(RATIO - 1)) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  fifo_mem_sp256 #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_sel  (sub_idx),
    .rd_data (bus.rd_data)
  );
endmodule

// File: tb/tb_fifo_256i_16o.sv
// tb/tb_fifo_256i_16o.sv - randomized self-checking bench against a halfword-queue model
module tb_fifo_256i_16o;
  import fifo_256i_16o_pkg::*;

  localparam int DEPTH = 1024;
  localparam int AF    = 1008;
  localparam int AE    = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_256i_16o_if bus();

  fifo_256i_16o #(.DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_wr_acc = 0;
  logic [15:0] mq[$];
  logic [15:0] exp_rd = '0;

  function automatic int m_wlvl();
    return (mq.size() + 15) / 16;
  endfunction

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  // Drive one cycle and advance the model: a FIFO of halfwords.
  task automatic do_cycle(input logic we, input logic [255:0] wd, input logic re);
    bit full, empty;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    full  = (m_wlvl() == DEPTH);
    empty = (mq.size() == 0);
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      exp_rd = '0;
    end else begin
      if (re && !empty) exp_rd = mq.pop_front();
      if (we && !full) begin
        for (int k = 0; k < 16; k++) mq.push_back(wd[16*k +: 16]);
        n_wr_acc++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    do_cycle(1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    do_cycle(1'b1, rand_word(), 1'b1);
    do_cycle(1'b1, rand_word(), 1'b1);
    n_cmp++; if (bus.rd_empty !== 1'b1) begin n_bad++; $display("FAIL reset_rd_empty got %0b want 1", bus.rd_empty); end
    n_cmp++; if (bus.almost_empty !== 1'b1) begin n_bad++; $display("FAIL reset_almost_empty got %0b want 1", bus.almost_empty); end
    n_cmp++; if (bus.wr_full !== 1'b0) begin n_bad++; $display("FAIL reset_wr_full got %0b want 0", bus.wr_full); end
    n_cmp++; if (bus.almost_full !== 1'b0) begin n_bad++; $display("FAIL reset_almost_full got %0b want 0", bus.almost_full); end
    n_cmp++; if (bus.wr_water_level !== 11'd0) begin n_bad++; $display("FAIL reset_wr_level got %0d want 0", bus.wr_water_level); end
    n_cmp++; if (bus.rd_water_level !== 15'd0) begin n_bad++; $display("FAIL reset_rd_level got %0d want 0", bus.rd_water_level); end
    n_cmp++; if (bus.rd_data !== 16'h0) begin n_bad++; $display("FAIL reset_rd_data got %0h want 0", bus.rd_data); end
    rst = 1'b0;
    do_cycle(1'b0, '0, 1'b0);
    n_cmp++; if (bus.rd_empty !== 1'b1) begin n_bad++; $display("FAIL reset_override_wr got rd_empty %0b want 1", bus.rd_empty); end
  endtask

  task automatic test_single_word();
    logic [255:0] w;
    for (int k = 0; k < 16; k++) w[16*k +: 16] = 16'(k);
    do_cycle(1'b1, w, 1'b0);
    n_cmp++; if (bus.rd_empty !== 1'b0) begin n_bad++; $display("FAIL single_not_empty got %0b want 0", bus.rd_empty); end
    n_cmp++; if (bus.rd_water_level !== 15'd16) begin n_bad++; $display("FAIL single_rd_level got %0d want 16", bus.rd_water_level); end
    for (int i = 0; i < 16; i++) begin
      do_cycle(1'b0, '0, 1'b1);
      n_cmp++; if (bus.rd_data !== 16'(i)) begin n_bad++; $display("FAIL single_rd_data[%0d] got %0h want %0h", i, bus.rd_data, i); end
      n_cmp++; if (bus.wr_water_level !== ((i == 15) ? 11'd0 : 11'd1)) begin n_bad++; $display("FAIL single_wr_level[%0d] got %0d want %0d", i, bus.wr_water_level, (i == 15) ? 0 : 1); end
    end
    n_cmp++; if (bus.rd_empty !== 1'b1) begin n_bad++; $display("FAIL single_empty_after got %0b want 1", bus.rd_empty); end
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b1, rand_word(), 1'b0);
      n_cmp++; if (bus.wr_water_level !== 11'(i + 1)) begin n_bad++; $display("FAIL fill_wr_level got %0d want %0d", bus.wr_water_level, i + 1); end
      n_cmp++; if (bus.almost_full !== (i + 1 >= AF)) begin n_bad++; $display("FAIL fill_almost_full at %0d got %0b want %0b", i + 1, bus.almost_full, i + 1 >= AF); end
      n_cmp++; if (bus.wr_full !== (i + 1 == DEPTH)) begin n_bad++; $display("FAIL fill_wr_full at %0d got %0b want %0b", i + 1, bus.wr_full, i + 1 == DEPTH); end
    end
    do_cycle(1'b1, rand_word(), 1'b0);
    n_cmp++; if (bus.rd_water_level !== 15'(16 * DEPTH)) begin n_bad++; $display("FAIL full_extra_write got %0d want %0d", bus.rd_water_level, 16 * DEPTH); end
    n_cmp++; if (bus.wr_full !== 1'b1) begin n_bad++; $display("FAIL full_flag got %0b want 1", bus.wr_full); end
  endtask

  task automatic test_drain_full();
    do_cycle(1'b0, '0, 1'b1);
    n_cmp++; if (bus.rd_data !== exp_rd) begin n_bad++; $display("FAIL drain_first_data got %0h want %0h", bus.rd_data, exp_rd); end
    n_cmp++; if (bus.wr_water_level !== 11'(DEPTH)) begin n_bad++; $display("FAIL drain_level_held got %0d want %0d", bus.wr_water_level, DEPTH); end
    n_cmp++; if (bus.wr_full !== 1'b1) begin n_bad++; $display("FAIL drain_full_held got %0b want 1", bus.wr_full); end
    for (int i = 1; i < 15; i++) begin
      do_cycle(1'b0, '0, 1'b1);
      n_cmp++; if (bus.rd_data !== exp_rd) begin n_bad++; $display("FAIL drain_data[%0d] got %0h want %0h", i, bus.rd_data, exp_rd); end
    end
    // The write on the 16th read still sees the slot as occupied.
    do_cycle(1'b1, rand_word(), 1'b1);
    n_cmp++; if (bus.rd_data !== exp_rd) begin n_bad++; $display("FAIL drain_last_data got %0h want %0h", bus.rd_data, exp_rd); end
    n_cmp++; if (bus.wr_water_level !== 11'(DEPTH - 1)) begin n_bad++; $display("FAIL drain_level_freed got %0d want %0d", bus.wr_water_level, DEPTH - 1); end
    n_cmp++; if (bus.wr_full !== 1'b0) begin n_bad++; $display("FAIL drain_full_clear got %0b want 0", bus.wr_full); end
    n_cmp++; if (bus.rd_water_level !== 15'(16 * DEPTH - 16)) begin n_bad++; $display("FAIL drain_rd_level got %0d want %0d", bus.rd_water_level, 16 * DEPTH - 16); end
  endtask

  task automatic test_simul();
    do_cycle(1'b1, rand_word(), 1'b0);
    for (int i = 0; i < 11; i++) do_cycle(1'b0, '0, 1'b1);
    n_cmp++; if (bus.rd_water_level !== 15'd5) begin n_bad++; $display("FAIL simul_pre_cnt got %0d want 5", bus.rd_water_level); end
    do_cycle(1'b1, rand_word(), 1'b1);
    n_cmp++; if (bus.rd_water_level !== 15'd20) begin n_bad++; $display("FAIL simul_cnt got %0d want 20", bus.rd_water_level); end
    n_cmp++; if (bus.wr_water_level !== 11'd2) begin n_bad++; $display("FAIL simul_wr_level got %0d want 2", bus.wr_water_level); end
    n_cmp++; if (bus.rd_data !== exp_rd) begin n_bad++; $display("FAIL simul_rd_data got %0h want %0h", bus.rd_data, exp_rd); end
  endtask

  task automatic test_read_empty();
    logic [15:0] hold;
    for (int i = 0; i < 100 && mq.size() != 0; i++) begin
      do_cycle(1'b0, '0, 1'b1);
      n_cmp++; if (bus.rd_data !== exp_rd) begin n_bad++; $display("FAIL empty_drain_data got %0h want %0h", bus.rd_data, exp_rd); end
    end
    hold = exp_rd;
    do_cycle(1'b0, '0, 1'b1);
    do_cycle(1'b0, '0, 1'b1);
    n_cmp++; if (bus.rd_data !== hold) begin n_bad++; $display("FAIL empty_rd_hold got %0h want %0h", bus.rd_data, hold); end
    n_cmp++; if (bus.rd_water_level !== 15'd0) begin n_bad++; $display("FAIL empty_cnt got %0d want 0", bus.rd_water_level); end
    n_cmp++; if (bus.rd_empty !== 1'b1) begin n_bad++; $display("FAIL empty_flag got %0b want 1", bus.rd_empty); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] w;
    for (int i = 0; i < 3; i++) do_cycle(1'b1, rand_word(), 1'b0);
    for (int i = 0; i < 8; i++) do_cycle(1'b0, '0, 1'b1);
    n_cmp++; if (bus.rd_water_level !== 15'd40) begin n_bad++; $display("FAIL mid_pre_cnt got %0d want 40", bus.rd_water_level); end
    rst = 1'b1;
    do_cycle(1'b1, rand_word(), 1'b1);
    rst = 1'b0;
    n_cmp++; if (bus.rd_empty !== 1'b1) begin n_bad++; $display("FAIL mid_rd_empty got %0b want 1", bus.rd_empty); end
    n_cmp++; if (bus.rd_water_level !== 15'd0 || bus.wr_water_level !== 11'd0) begin n_bad++; $display("FAIL mid_levels got %0d/%0d want 0/0", bus.rd_water_level, bus.wr_water_level); end
    n_cmp++; if (bus.rd_data !== 16'h0) begin n_bad++; $display("FAIL mid_rd_data got %0h want 0", bus.rd_data); end
    w = rand_word();
    do_cycle(1'b1, w, 1'b0);
    for (int i = 0; i < 16; i++) begin
      do_cycle(1'b0, '0, 1'b1);
      n_cmp++; if (bus.rd_data !== w[16*i +: 16]) begin n_bad++; $display("FAIL mid_new_data[%0d] got %0h want %0h", i, bus.rd_data, w[16*i +: 16]); end
    end
    n_cmp++; if (bus.rd_empty !== 1'b1) begin n_bad++; $display("FAIL mid_no_stale got rd_empty %0b want 1", bus.rd_empty); end
  endtask

  task automatic test_wrap();
    bit done = 0;
    bit we, re, empty;
    int n_rd = 0;
    n_wr_acc = 0;
    for (int cyc = 0; cyc < 60000 && !done; cyc++) begin
      we    = (n_wr_acc < 3 * DEPTH) && ($urandom_range(3) != 0);
      re    = ($urandom_range(15) != 0);
      empty = (mq.size() == 0);
      do_cycle(we, rand_word(), re);
      if (re && !empty) begin
        n_rd++;
        n_cmp++; if (bus.rd_data !== exp_rd) begin n_bad++; $display("FAIL wrap_rd_data at read %0d got %0h want %0h", n_rd, bus.rd_data, exp_rd); end
      end
      n_cmp++; if (bus.rd_water_level !== 15'(mq.size())) begin n_bad++; $display("FAIL wrap_rd_level got %0d want %0d", bus.rd_water_level, mq.size()); end
      n_cmp++; if (bus.wr_full !== (m_wlvl() == DEPTH)) begin n_bad++; $display("FAIL wrap_wr_full got %0b want %0b", bus.wr_full, m_wlvl() == DEPTH); end
      n_cmp++; if (bus.almost_empty !== (mq.size() <= AE)) begin n_bad++; $display("FAIL wrap_almost_empty got %0b want %0b", bus.almost_empty, mq.size() <= AE); end
      if (n_wr_acc == 3 * DEPTH && mq.size() == 0) done = 1;
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL wrap_timeout got %0d writes want %0d", n_wr_acc, 3 * DEPTH); end
    n_cmp++; if (n_rd !== 3 * DEPTH * 16) begin n_bad++; $display("FAIL wrap_read_count got %0d want %0d", n_rd, 3 * DEPTH * 16); end
  endtask

  initial begin
    rst          = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.rd_en    = 1'b0;
    test_reset();
    test_single_word();
    test_fill_full();
    test_drain_full();
    do_reset();
    test_simul();
    test_read_empty();
    test_reset_mid();
    do_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
